// File: rtl/host_bus_initiator.sv
// host_bus_initiator: host request to strobed 8-bit register bus, word accesses split into even/odd byte cycles.
module host_bus_initiator #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_rd_nwr_i,
    input  logic [3:0]  req_reg_num_i,
    input  logic        req_byte_i,
    input  logic        req_bytesel_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic        bus_cs_n_o,
    output logic        bus_rd_nwr_o,
    output logic [3:0]  bus_reg_num_o,
    output logic        bus_bytesel_o,
    output logic [7:0]  bus_data_o,
    output logic        bus_data_oe_o,
    input  logic [7:0]  bus_data_i
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    localparam logic [3:0] SETUP_END  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_END = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_END   = 4'(HOLD_CYCLES - 1);
    state_t      state;
    logic        phase;
    logic [3:0]  cnt;
    logic        lat_rd;
    logic        lat_byte;
    logic [7:0]  lat_lo;
    logic [15:0] rd_buf;
    assign req_ready_o = state == IDLE;
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state         <= IDLE;
            phase         <= 1'b0;
            cnt           <= 4'd0;
            lat_rd        <= 1'b1;
            lat_byte      <= 1'b0;
            lat_lo        <= 8'd0;
            rd_buf        <= 16'd0;
            bus_cs_n_o    <= 1'b1;
            bus_rd_nwr_o  <= 1'b1;
            bus_reg_num_o <= 4'd0;
            bus_bytesel_o <= 1'b0;
            bus_data_o    <= 8'd0;
            bus_data_oe_o <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_data_o    <= 16'd0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                IDLE: if (req_valid_i) begin
                    state         <= SETUP;
                    cnt           <= 4'd0;
                    phase         <= 1'b0;
                    lat_rd        <= req_rd_nwr_i;
                    lat_byte      <= req_byte_i;
                    lat_lo        <= req_data_i[7:0];
                    bus_rd_nwr_o  <= req_rd_nwr_i;
                    bus_reg_num_o <= req_reg_num_i;
                    bus_bytesel_o <= req_byte_i & req_bytesel_i;
                    bus_data_o    <= req_byte_i ? req_data_i[7:0] : req_data_i[15:8];
                    bus_data_oe_o <= ~req_rd_nwr_i;
                end
                SETUP: if (cnt == SETUP_END) begin
                    state      <= STROBE;
                    cnt        <= 4'd0;
                    bus_cs_n_o <= 1'b0;
                end else cnt <= cnt + 4'd1;
                STROBE: if (cnt == STROBE_END) begin
                    state      <= HOLD;
                    cnt        <= 4'd0;
                    bus_cs_n_o <= 1'b1;
                    if (phase | lat_byte) rd_buf[7:0] <= bus_data_i;
                    else rd_buf[15:8] <= bus_data_i;
                end else cnt <= cnt + 4'd1;
                HOLD: if (cnt == HOLD_END) begin
                    cnt <= 4'd0;
                    // word: even byte done, rerun the byte cycle for the odd lane
                    if (!lat_byte && !phase) begin
                        phase         <= 1'b1;
                        state         <= SETUP;
                        bus_bytesel_o <= 1'b1;
                        bus_data_o    <= lat_lo;
                    end else begin
                        state         <= IDLE;
                        phase         <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        bus_rd_nwr_o  <= 1'b1;
                        bus_data_oe_o <= 1'b0;
                        if (lat_rd) rsp_data_o <= lat_byte ? {8'h00, rd_buf[7:0]} : rd_buf;
                    end
                end else cnt <= cnt + 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_host_bus_initiator.sv
// tb_host_bus_initiator: timing-model check of two initiators (default and 2/3/2 cycle parameters).
module tb_host_bus_initiator;
    logic        clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset = 1'b1;
    logic [1:0]  valid = 2'b00;
    logic        rd = 1'b0, byt = 1'b0, bsel = 1'b0;
    logic [3:0]  regn = 4'd0;
    logic [15:0] wdata = 16'd0;
    logic [7:0]  bdi = 8'd0;
    logic [1:0]  ready, rsp_valid, cs_n, rd_nwr, bsel_o, oe;
    logic [3:0]  reg_o [2];
    logic [7:0]  data_o [2];
    logic [15:0] rsp_data [2];
    logic [15:0] exp_rsp [2];
    int n_chk = 0, n_fail = 0;

    host_bus_initiator u0 (
        .clk(clk), .reset_i(reset), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_rd_nwr_i(rd), .req_reg_num_i(regn), .req_byte_i(byt), .req_bytesel_i(bsel),
        .req_data_i(wdata), .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]),
        .bus_cs_n_o(cs_n[0]), .bus_rd_nwr_o(rd_nwr[0]), .bus_reg_num_o(reg_o[0]),
        .bus_bytesel_o(bsel_o[0]), .bus_data_o(data_o[0]), .bus_data_oe_o(oe[0]), .bus_data_i(bdi)
    );
    host_bus_initiator #(.SETUP_CYCLES(2), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u1 (
        .clk(clk), .reset_i(reset), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_rd_nwr_i(rd), .req_reg_num_i(regn), .req_byte_i(byt), .req_bytesel_i(bsel),
        .req_data_i(wdata), .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]),
        .bus_cs_n_o(cs_n[1]), .bus_rd_nwr_o(rd_nwr[1]), .bus_reg_num_o(reg_o[1]),
        .bus_bytesel_o(bsel_o[1]), .bus_data_o(data_o[1]), .bus_data_oe_o(oe[1]), .bus_data_i(bdi)
    );

    // One access from the acceptance request through the rsp_valid cycle; returns at that cycle's negedge.
    task automatic do_access(input int sel, input logic b2b, input logic i_rd, input logic i_byt,
                             input logic i_bsel, input logic [3:0] i_reg, input logic [15:0] i_data,
                             input logic [7:0] rb0, input logic [7:0] rb1);
        int s, t, h, per, n, p, o;
        logic e_cs, e_bsel;
        logic [7:0] e_data;
        logic [15:0] e_rsp;
        s = sel ? 2 : 1;
        t = sel ? 3 : 2;
        h = sel ? 2 : 1;
        per = s + t + h;
        n = (i_byt ? 1 : 2) * per;
        if (!b2b) begin
            @(posedge clk); #1;
            n_chk++;
            if (rsp_valid[sel] !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_pulse_width dut%0d got %b want 0", sel, rsp_valid[sel]);
            end
        end
        valid[sel] = 1'b1; rd = i_rd; byt = i_byt; bsel = i_bsel; regn = i_reg; wdata = i_data;
        #2;
        n_chk++;
        if (ready[sel] !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready dut%0d got %b want 1", sel, ready[sel]);
        end
        @(posedge clk); #1;
        for (int k = 1; k <= n + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            p = (k - 1) / per;
            o = (k - 1) % per;
            valid[sel] = (k <= n) ? 1'($urandom) : 1'b0;
            rd = 1'($urandom); byt = 1'($urandom); bsel = 1'($urandom);
            regn = 4'($urandom); wdata = 16'($urandom);
            bdi = (k <= n && o == s + t - 1) ? (p != 0 ? rb1 : rb0) : 8'($urandom);
            @(negedge clk);
            if (k <= n) begin
                e_cs = !(o >= s && o < s + t);
                e_bsel = i_byt ? i_bsel : (p != 0);
                e_data = (i_byt || p != 0) ? i_data[7:0] : i_data[15:8];
                n_chk++;
                if (cs_n[sel] !== e_cs) begin
                    n_fail++;
                    $display("FAIL cs_n dut%0d cycle %0d got %b want %b", sel, k, cs_n[sel], e_cs);
                end
                n_chk++;
                if ({oe[sel], rd_nwr[sel], reg_o[sel], bsel_o[sel], data_o[sel]} !== {!i_rd, i_rd, i_reg, e_bsel, e_data}) begin
                    n_fail++;
                    $display("FAIL bus_fields dut%0d cycle %0d got oe=%b rd=%b reg=%h bsel=%b data=%h want oe=%b rd=%b reg=%h bsel=%b data=%h",
                             sel, k, oe[sel], rd_nwr[sel], reg_o[sel], bsel_o[sel], data_o[sel], !i_rd, i_rd, i_reg, e_bsel, e_data);
                end
                n_chk++;
                if ({rsp_valid[sel], ready[sel]} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL busy_handshake dut%0d cycle %0d got rsp_valid,ready=%b want 00", sel, k, {rsp_valid[sel], ready[sel]});
                end
            end else begin
                e_rsp = !i_rd ? exp_rsp[sel] : (i_byt ? {8'h00, rb0} : {rb0, rb1});
                e_bsel = i_byt ? i_bsel : 1'b1;
                n_chk++;
                if ({rsp_valid[sel], ready[sel], cs_n[sel], oe[sel], rd_nwr[sel], reg_o[sel], bsel_o[sel], data_o[sel]}
                    !== {5'b11101, i_reg, e_bsel, i_data[7:0]}) begin
                    n_fail++;
                    $display("FAIL done_cycle dut%0d cycle %0d got v=%b rdy=%b cs=%b oe=%b rd=%b reg=%h bsel=%b data=%h want 1 1 1 0 1 %h %b %h",
                             sel, k, rsp_valid[sel], ready[sel], cs_n[sel], oe[sel], rd_nwr[sel], reg_o[sel], bsel_o[sel], data_o[sel],
                             i_reg, e_bsel, i_data[7:0]);
                end
                n_chk++;
                if (rsp_data[sel] !== e_rsp) begin
                    n_fail++;
                    $display("FAIL rsp_data dut%0d got %h want %h", sel, rsp_data[sel], e_rsp);
                end
                exp_rsp[sel] = e_rsp;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid = 2'b11; rd = 1'b0; regn = 4'hF; wdata = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if ({cs_n[d], rd_nwr[d], reg_o[d], bsel_o[d], data_o[d], oe[d], rsp_valid[d], rsp_data[d]} !== {2'b11, 4'h0, 1'b0, 8'h00, 2'b00, 16'h0000}) begin
                n_fail++;
                $display("FAIL reset_values dut%0d got cs=%b rd=%b reg=%h bsel=%b data=%h oe=%b v=%b rsp=%h",
                         d, cs_n[d], rd_nwr[d], reg_o[d], bsel_o[d], data_o[d], oe[d], rsp_valid[d], rsp_data[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; valid = 2'b00;
        @(negedge clk);
        n_chk++;
        if ({ready, cs_n} !== 4'b1111) begin
            n_fail++;
            $display("FAIL no_accept_in_reset got ready=%b cs_n=%b want 11 11", ready, cs_n);
        end
        exp_rsp[0] = 16'h0; exp_rsp[1] = 16'h0;
    endtask

    task automatic test_word_write();
        do_access(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 16'hA55A, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_word_read();
        do_access(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 16'($urandom), 8'h12, 8'h34);
        n_chk++;
        if (rsp_data[0] !== 16'h1234) begin
            n_fail++;
            $display("FAIL word_read_value got %h want 1234", rsp_data[0]);
        end
    endtask

    task automatic test_byte_write();
        do_access(0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd9, 16'h00C3, 8'($urandom), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        do_access(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 16'hBEEF, 8'h00, 8'h00);
        do_access(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h1357, 8'h9A, 8'hBC);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        valid[0] = 1'b1; rd = 1'b0; byt = 1'b0; regn = 4'd7; wdata = 16'h6655;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        @(posedge clk); #1;
        n_chk++;
        if (cs_n[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_strobe_active got cs_n=%b want 0", cs_n[0]);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_rsp[0] = 16'h0; exp_rsp[1] = 16'h0;
        n_chk++;
        if ({cs_n[0], rsp_valid[0], ready[0], oe[0], rsp_data[0]} !== {4'b1010, 16'h0}) begin
            n_fail++;
            $display("FAIL abort_state got cs=%b v=%b rdy=%b oe=%b rsp=%h want 1 0 1 0 0000",
                     cs_n[0], rsp_valid[0], ready[0], oe[0], rsp_data[0]);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_chk++;
            if ({rsp_valid[0], cs_n[0]} !== 2'b01) begin
                n_fail++;
                $display("FAIL abort_quiet cycle %0d got v=%b cs=%b want 0 1", k, rsp_valid[0], cs_n[0]);
            end
        end
        do_access(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0, 8'h5C, 8'hA3);
    endtask

    task automatic test_timing_params();
        do_access(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6, 16'($urandom), 8'h7E, 8'($urandom));
        n_chk++;
        if (rsp_data[1] !== 16'h007E) begin
            n_fail++;
            $display("FAIL slow_byte_read got %h want 007E", rsp_data[1]);
        end
    endtask

    task automatic test_random();
        int sel;
        sel = 0;
        for (int i = 0; i < 30; i++) begin
            int nsel;
            nsel = int'($urandom_range(1, 0));
            do_access(nsel, (nsel == sel && i > 0) ? 1'($urandom) : 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
            sel = nsel;
        end
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_word_read();
        test_byte_write();
        test_back_to_back();
        test_reset_mid();
        test_timing_params();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/host_bus_initiator.md
HOST_BUS_INITIATOR -- requirements
Module: host_bus_initiator

Interface
REQ-001 SETUP_CYCLES, 1, clocks of address/data setup before strobe; legal 1..15.
REQ-002 STROBE_CYCLES, 2, clocks bus_cs_n_o held low per byte; legal 1..15.
REQ-003 HOLD_CYCLES, 1, clocks of address/data hold after strobe; legal 1..15.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  1  host request present.
REQ-007 req_ready_o  output  1  request accepted on the edge where valid & ready.
REQ-008 req_rd_nwr_i  input  1  0 = write, 1 = read.
REQ-009 req_reg_num_i  input  4  target register number.
REQ-010 req_byte_i  input  1  1 = single byte access, 0 = 16-bit word (two byte cycles).
REQ-011 req_bytesel_i  input  1  byte lane for byte access (0 even, 1 odd); ignored for word.
REQ-012 req_data_i  input  16  write data; byte access uses [7:0].
REQ-013 rsp_valid_o  output  1  one-cycle pulse: access complete.
REQ-014 rsp_data_o  output  16  read result; held until next rsp_valid_o.
REQ-015 bus_cs_n_o  output  1  register select strobe, active low.
REQ-016 bus_rd_nwr_o  output  1  0 = write, 1 = read.
REQ-017 bus_reg_num_o  output  4  register number.
REQ-018 bus_bytesel_o  output  1  0 = even byte, 1 = odd byte.
REQ-019 bus_data_o  output  8  write byte.
REQ-020 bus_data_oe_o  output  1  1 = initiator drives data bus.
REQ-021 bus_data_i  input  8  read byte from responder.

Function
REQ-022 States SHALL be IDLE, SETUP, STROBE, HOLD; plus 1-bit byte phase and 4-bit cycle counter.
REQ-023 req_ready_o SHALL equal (state == IDLE); request fields SHALL be latched on acceptance edge and input changes afterwards ignored.
REQ-024 Acceptance SHALL enter SETUP; SETUP lasts SETUP_CYCLES, then STROBE lasts STROBE_CYCLES, then HOLD lasts HOLD_CYCLES.
REQ-025 bus_cs_n_o SHALL be 0 only in STROBE; bus_reg_num_o, bus_rd_nwr_o, bus_bytesel_o, bus_data_o SHALL be stable through SETUP, STROBE, HOLD of a byte.
REQ-026 Word access: phase 0 bytesel 0 carrying req_data_i[15:8]; phase 1 bytesel 1 carrying req_data_i[7:0]; HOLD of phase 0 goes to SETUP of phase 1.
REQ-027 Byte access: single phase using latched req_bytesel_i and req_data_i[7:0].
REQ-028 Reads: bus_data_i SHALL be sampled on the edge ending the last STROBE cycle; word result {even, odd}; byte result {8'h00, byte}.
REQ-029 bus_data_oe_o SHALL be 1 in SETUP/STROBE/HOLD of writes only; always 0 for reads and in IDLE.
REQ-030 Edge ending final HOLD SHALL enter IDLE and assert rsp_valid_o for exactly that next cycle (concurrent with req_ready_o = 1); rsp_data_o updates only then, and only for reads (writes leave it unchanged).
REQ-031 Latency: word completes with rsp_valid_o in cycle 2*(S+T+H)+1 after acceptance edge; byte in cycle (S+T+H)+1; back-to-back accept in the rsp_valid_o cycle permitted.
REQ-032 Between consecutive strobes bus_cs_n_o SHALL be high for at least HOLD_CYCLES+SETUP_CYCLES clocks.
REQ-033 In IDLE: bus_cs_n_o 1, bus_rd_nwr_o 1, bus_data_oe_o 0; other bus outputs hold last values.

Reset
REQ-034 reset_i SHALL force IDLE, phase 0, counter 0, bus_cs_n_o 1, bus_rd_nwr_o 1, bus_reg_num_o 0, bus_bytesel_o 0, bus_data_o 0, bus_data_oe_o 0, rsp_valid_o 0, rsp_data_o 0.
REQ-035 Requests SHALL NOT be accepted while reset_i is 1; reset mid-access aborts with no rsp_valid_o and bus_cs_n_o 1 the cycle after the reset edge.

Verification
REQ-036 Word write 0xA55A reg 3, defaults -> cs_n low cycles 2-3 bytesel 0 data 0xA5, cycles 6-7 bytesel 1 data 0x5A; oe 1 cycles 1-8; rsp_valid cycle 9.
REQ-037 Word read reg 5, responder drives 0x12 then 0x34 during strobes -> rsp_data_o 0x1234 in cycle 9; oe 0 throughout; rd_nwr 1.
REQ-038 Byte write, bytesel 1, data 0x00C3 -> one strobe (cycles 2-3) bytesel 1 data 0xC3; rsp_valid cycle 5.
REQ-039 req_valid_i held high with two word requests -> second accepted in cycle 9; cs_n high >= 2 clocks between strobes; input changes while busy ignored.
REQ-040 reset_i pulsed during phase 0 STROBE -> cs_n 1 next cycle, no rsp_valid, ready 1 after reset release, next request runs normally.
REQ-041 SETUP=2, STROBE=3, HOLD=2 byte read of 0x7E -> cs_n low cycles 3-5, rsp_data_o 0x007E in cycle 8.
